// File: rtl/load_store_unit.sv
// Load/store unit between a core request/response port and a 16 x 32-bit
// synchronous data memory (1-cycle read latency, write on falling edge).
// Supports word and byte loads/stores; byte loads can sign- or zero-extend.
// Misaligned word accesses return an error response without touching memory.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqValid/reqReady           request handshake
//   reqWrite, reqByte,          request attributes (store, byte access,
//   reqSigned, reqAddr, reqData  sign-extend, byte address, store data)
//   respValid/respReady         response handshake
//   respData, respError         load result / misalignment flag
//   memAddress, memWriteEnable, data memory word index, write strobe and
//   memWriteData, memData       write word; registered read word
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic        reqByte,
  input  logic        reqSigned,
  input  logic [5:0]  reqAddr,
  input  logic [31:0] reqData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respError,
  output logic [3:0]  memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  state_t      state, next_state;

  // Request attributes kept for the multi-cycle paths
  logic        lat_write;
  logic        lat_byte;
  logic        lat_signed;
  logic [1:0]  lat_lane;
  logic [7:0]  lat_wbyte;

  logic        accept;
  logic        misaligned;
  logic [7:0]  sel_byte;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  // Next-state logic and CAP-stage datapath
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    misaligned  = 1'b0;
    sel_byte    = 8'd0;
    merged_word = memData;

    case (lat_lane)
      2'd0: begin
        sel_byte    = memData[7:0];
        merged_word = {memData[31:8], lat_wbyte};
      end
      2'd1: begin
        sel_byte    = memData[15:8];
        merged_word = {memData[31:16], lat_wbyte, memData[7:0]};
      end
      2'd2: begin
        sel_byte    = memData[23:16];
        merged_word = {memData[31:24], lat_wbyte, memData[15:0]};
      end
      default: begin
        sel_byte    = memData[31:24];
        merged_word = {lat_wbyte, memData[23:0]};
      end
    endcase

    load_value = lat_byte ? {{24{lat_signed & sel_byte[7]}}, sel_byte} : memData;

    case (state)
      S_IDLE: begin
        accept     = reqValid & reqReady;
        misaligned = !reqByte && (reqAddr[1:0] != 2'd0);
        if (accept) begin
          if (misaligned)              next_state = S_RESP;
          else if (reqWrite && !reqByte) next_state = S_WR;
          else                         next_state = S_RD;
        end
      end
      S_RD:    next_state = S_CAP;
      // Only byte stores reach CAP with a write pending
      S_CAP:   next_state = lat_write ? S_WR : S_RESP;
      S_WR:    next_state = S_RESP;
      S_RESP:  if (respReady) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register; handshake and strobe outputs are registered decodes of
  // the next state so they change only at the rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      reqReady       <= 1'b1;
      respValid      <= 1'b0;
      respError      <= 1'b0;
      respData       <= 32'd0;
      memAddress     <= 4'd0;
      memWriteEnable <= 1'b0;
      memWriteData   <= 32'd0;
      lat_write      <= 1'b0;
      lat_byte       <= 1'b0;
      lat_signed     <= 1'b0;
      lat_lane       <= 2'd0;
      lat_wbyte      <= 8'd0;
    end else begin
      state          <= next_state;
      reqReady       <= (next_state == S_IDLE);
      respValid      <= (next_state == S_RESP);
      memWriteEnable <= (next_state == S_WR);

      if (accept) begin
        lat_write  <= reqWrite;
        lat_byte   <= reqByte;
        lat_signed <= reqSigned;
        lat_lane   <= reqAddr[1:0];
        lat_wbyte  <= reqData[7:0];
        respData   <= 32'd0;
        respError  <= misaligned;
        if (!misaligned) begin
          memAddress <= reqAddr[5:2];
          if (reqWrite && !reqByte) memWriteData <= reqData;
        end
      end

      if (state == S_CAP) begin
        if (lat_write) memWriteData <= merged_word;
        else           respData     <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural data memory, directed scenarios
// and a randomized sequence checked against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite, reqByte, reqSigned;
  logic [5:0]  reqAddr;
  logic [31:0] reqData;
  logic        respValid, respReady, respError;
  logic [31:0] respData;
  logic [3:0]  memAddress;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memData;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqByte(reqByte), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respReady(respReady), .respData(respData),
    .respError(respError), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memData(memData)
  );

  always #5 clk = ~clk;

  // Environment memory: registered read on rising edge, write on falling edge
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        preload;
  int          we_pulses = 0;
  logic [31:0] last_wdata = 32'd0;

  always @(posedge clk) memData <= mem[memAddress];

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    end else if (memWriteEnable) begin
      mem[memAddress] <= memWriteData;
      we_pulses       <= we_pulses + 1;
      last_wdata      <= memWriteData;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  model_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; expectations come from the reference model
  task automatic do_txn(input logic w, input logic b, input logic s,
                        input logic [5:0] addr, input logic [31:0] data,
                        input int hold, input string tag);
    logic        mis;
    logic [3:0]  widx;
    int          sh;
    int          lat_exp;
    int          v;
    int          n;
    int          p0;
    logic [31:0] word_now;
    logic [31:0] exp_data;
    mis      = !b && (addr[1:0] != 2'd0);
    widx     = addr[5:2];
    sh       = 8 * int'(addr[1:0]);
    word_now = ref_mem[widx];
    lat_exp  = mis ? 1 : (!w ? 3 : (b ? 4 : 2));
    exp_data = 32'd0;
    if (!mis && !w) begin
      if (b) begin
        v = int'((word_now >> sh) & 32'hFF);
        if (s && v > 127) v -= 256;
        exp_data = 32'(v);
      end else begin
        exp_data = word_now;
      end
    end
    if (!mis && w) begin
      if (b) ref_mem[widx] = (word_now & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
      else   ref_mem[widx] = data;
    end
    if (!mis) model_addr = widx;

    @(negedge clk);
    check({tag, "/ready"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqByte = b; reqSigned = s;
    reqAddr  = addr; reqData  = data;
    p0 = we_pulses;
    @(negedge clk);
    reqValid = 1'b0; reqWrite = 1'($urandom); reqByte = 1'($urandom);
    reqSigned = 1'($urandom); reqAddr = 6'($urandom); reqData = $urandom;
    n = 1;
    while (!respValid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(lat_exp));
    check({tag, "/data"}, respData, exp_data);
    check({tag, "/error"}, 32'(respError), 32'(mis));
    check({tag, "/addr"}, 32'(memAddress), 32'(model_addr));
    check({tag, "/busy"}, 32'(reqReady), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(respValid), 32'd1);
      check({tag, "/hold_data"}, respData, exp_data);
      check({tag, "/hold_busy"}, 32'(reqReady), 32'd0);
    end
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    check({tag, "/done_valid"}, 32'(respValid), 32'd0);
    check({tag, "/done_ready"}, 32'(reqReady), 32'd1);
    check({tag, "/pulses"}, 32'(we_pulses - p0), 32'(w && !mis));
    check({tag, "/mem"}, mem[widx], ref_mem[widx]);
    if (w && !mis) check({tag, "/wdata"}, last_wdata, ref_mem[widx]);
  endtask

  initial begin
    int p0;
    reset = 1'b1; preload = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqByte = 1'b0; reqSigned = 1'b0;
    reqAddr = 6'd0; reqData = 32'd0; respReady = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'h11223344;
    ref_mem[5] = 32'h000080FF;
    model_addr = 4'd0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check("rst/respValid", 32'(respValid), 32'd0);
    check("rst/respError", 32'(respError), 32'd0);
    check("rst/respData", respData, 32'd0);
    check("rst/memAddress", 32'(memAddress), 32'd0);
    check("rst/memWriteEnable", 32'(memWriteEnable), 32'd0);
    check("rst/memWriteData", memWriteData, 32'd0);
    check("rst/reqReady", 32'(reqReady), 32'd1);
    reset = 1'b0;

    // Directed scenarios
    do_txn(1'b0, 1'b0, 1'b0, 6'h0C, 32'd0, 0, "ld_word3");
    do_txn(1'b1, 1'b1, 1'b0, 6'h0D, 32'h000000AB, 0, "sb_0d");
    check("sb_0d/merged", last_wdata, 32'h1122AB44);
    do_txn(1'b0, 1'b0, 1'b0, 6'h0C, 32'd0, 0, "ld_after_sb");
    do_txn(1'b0, 1'b1, 1'b1, 6'h14, 32'd0, 0, "lb_14_s");
    do_txn(1'b0, 1'b1, 1'b1, 6'h15, 32'd0, 0, "lb_15_s");
    do_txn(1'b0, 1'b1, 1'b0, 6'h15, 32'd0, 0, "lb_15_u");
    do_txn(1'b0, 1'b0, 1'b0, 6'h0E, 32'd0, 0, "ld_misaligned");
    do_txn(1'b0, 1'b0, 1'b0, 6'h14, 32'd0, 5, "ld_hold5");
    do_txn(1'b1, 1'b0, 1'b0, 6'h24, 32'hCAFEF00D, 1, "sw_24");
    do_txn(1'b1, 1'b0, 1'b0, 6'h11, 32'hDEADBEEF, 0, "sw_misaligned");
    do_txn(1'b0, 1'b1, 1'b1, 6'h27, 32'd0, 0, "lb_27_s");

    // Reset while a byte store is in RD: no write, outputs back to reset values
    @(negedge clk);
    p0 = we_pulses;
    reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b1; reqSigned = 1'b0;
    reqAddr = 6'h0D; reqData = 32'h00000055;
    @(negedge clk);
    reqValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_addr = 4'd0;
    check("rst_rd/respValid", 32'(respValid), 32'd0);
    check("rst_rd/respError", 32'(respError), 32'd0);
    check("rst_rd/respData", respData, 32'd0);
    check("rst_rd/memAddress", 32'(memAddress), 32'd0);
    check("rst_rd/memWriteEnable", 32'(memWriteEnable), 32'd0);
    check("rst_rd/memWriteData", memWriteData, 32'd0);
    check("rst_rd/reqReady", 32'(reqReady), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_rd/pulses", 32'(we_pulses - p0), 32'd0);
    check("rst_rd/mem3", mem[3], ref_mem[3]);

    // Reset during WR: that cycle's write still lands, then nothing follows
    @(negedge clk);
    p0 = we_pulses;
    reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b0;
    reqAddr = 6'h20; reqData = 32'h5A5AA5A5;
    ref_mem[8] = 32'h5A5AA5A5;
    @(negedge clk);
    reqValid = 1'b0;
    check("rst_wr/strobe", 32'(memWriteEnable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_addr = 4'd0;
    check("rst_wr/strobe_off", 32'(memWriteEnable), 32'd0);
    check("rst_wr/no_resp", 32'(respValid), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_wr/no_resp_late", 32'(respValid), 32'd0);
    check("rst_wr/pulses", 32'(we_pulses - p0), 32'd1);
    check("rst_wr/mem8", mem[8], ref_mem[8]);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom),
             $urandom, int'($urandom_range(0, 2)), "rand");
    end

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; memory geometry fixed at 16 words x 32 bits, byte address 6 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqValid  in  1  core request present.
REQ-005 reqReady  out  1  unit can accept a request this cycle.
REQ-006 reqWrite  in  1  1 = store, 0 = load.
REQ-007 reqByte  in  1  1 = byte access, 0 = word access.
REQ-008 reqSigned  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 reqAddr  in  6  byte address; word index = reqAddr[5:2], lane = reqAddr[1:0].
REQ-010 reqData  in  32  store data; byte store uses bits [7:0].
REQ-011 respValid  out  1  response available.
REQ-012 respReady  in  1  core accepts the response.
REQ-013 respData  out  32  load result; 0 for stores and errors.
REQ-014 respError  out  1  misaligned word access.
REQ-015 memAddress  out  4  word index to data memory.
REQ-016 memWriteEnable  out  1  write strobe to data memory; memory commits on the falling edge of the cycle.
REQ-017 memWriteData  out  32  write word to data memory.
REQ-018 memData  in  32  read word from data memory, registered by memory on rising edge (1-cycle read latency).

Function
REQ-019 FSM states: IDLE, RD, CAP, WR, RESP.
REQ-020 IDLE: reqReady=1; all other states reqReady=0.
REQ-021 Accept = reqValid & reqReady at a rising edge; latch reqWrite, reqByte, reqSigned, reqAddr and reqData.
REQ-022 Accepted word access with reqAddr[1:0]!=0 goes to RESP with respError=1 and respData=0; memWriteEnable stays 0 and memAddress is not updated.
REQ-023 Accepted aligned word store goes to WR; memWriteData=reqData.
REQ-024 Accepted load or byte store goes to RD.
REQ-025 memAddress is a register loaded with reqAddr[5:2] on every non-error accept and held in all states until the next accept.
REQ-026 RD: memWriteEnable=0; unconditional transition to CAP.
REQ-027 CAP (memData valid) for word load: capture memData into respData, then go to RESP.
REQ-028 CAP for byte load: select byte memData[8*lane+7:8*lane], little-endian, extended per reqSigned to 32 bits; then RESP.
REQ-029 CAP for byte store: memWriteData = memData with lane byte replaced by reqData[7:0]; then WR.
REQ-030 WR: memWriteEnable=1 for exactly this one cycle, driven from the state register (no glitch before the falling edge); then RESP with respData=0.
REQ-031 RESP: respValid=1; respData and respError are held stable until respReady=1 at a rising edge, which returns the FSM to IDLE.
REQ-032 A new request cannot be accepted in the cycle the response completes; earliest next accept is the following IDLE cycle.
REQ-033 Latency from the accept edge to the first respValid cycle is 3 cycles for a load, 2 for a word store, 4 for a byte store, and 1 for an error.
REQ-034 memWriteEnable is 0 in every state except WR.

Reset
REQ-035 reset=1 at a rising edge: state=IDLE; respValid=0, respError=0, respData=0, memAddress=0, memWriteEnable=0, memWriteData=0, internal latches 0.
REQ-036 Reset has priority over accept and every other transition.
REQ-037 Reset asserted during WR does not suppress that cycle's falling-edge write; from the next cycle on, memWriteEnable=0 and no response is produced.

Verification
REQ-038 Memory word 3 = 0x11223344; load word at address 0x0C, respReady=1 -> respValid at accept+3, respData=0x11223344, respError=0.
REQ-039 Word 3 = 0x11223344; byte store at address 0x0D with reqData=0x000000AB -> one-cycle memWriteEnable, memWriteData=0x1122AB44; a subsequent word load returns 0x1122AB44.
REQ-040 Word 5 = 0x000080FF; byte load at 0x14 with signed=1 -> 0xFFFFFFFF; byte load at 0x15 with signed=1 -> 0xFFFFFF80; byte load at 0x15 with signed=0 -> 0x00000080.
REQ-041 Word load at 0x0E -> respError=1 and respData=0 at accept+1, no memWriteEnable pulse, memAddress unchanged.
REQ-042 Hold respReady=0 for 5 cycles during a load response -> respValid and respData are stable and reqReady=0 throughout; after respReady=1, the FSM reaches IDLE and the next accept is taken one cycle later.
REQ-043 Assert reset during RD of a byte store -> no memWriteEnable pulse, memory contents unchanged, all outputs at their reset values, reqReady=1 on the next cycle.
